// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared types and constants for the register-file writeback
//                arbiter: writeback request record, requester identifiers
//                and the hard-wired zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   // Default widths of a writeback record (32-bit datapath, 32 registers)
   localparam int WB_BIT_WIDTH = 32;
   localparam int WB_REG_WIDTH = $clog2(WB_BIT_WIDTH);

   // Register index that is hard-wired to zero; writes to it are discarded
   localparam int REG_ZERO = 0;

   // Writeback requester identifiers
   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_src_e;

   // One writeback request: destination register and data
   typedef struct packed {
      logic [WB_REG_WIDTH-1:0] rd;
      logic [WB_BIT_WIDTH-1:0] data;
   } wb_req_t;

   // The requester that is not 's'
   function automatic wb_src_e wb_other(input wb_src_e s);
      return (s == WB_ALU) ? WB_MEM : WB_ALU;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_slot.sv
`default_nettype none
// ============================================================================
//  Module      : wb_slot
//  Description : One-entry writeback buffer behind a valid/ready handshake.
//                The slot accepts a new entry when empty or when it is being
//                drained in the same cycle. Entries addressed to register 0
//                are accepted but dropped, so they never request a write.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_slot
   import regfile_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int REG_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid,
   output logic                 ready,
   input  logic [REG_WIDTH-1:0] in_reg,
   input  logic [BIT_WIDTH-1:0] in_data,
   input  logic                 drain,
   output logic                 full,
   output logic                 fill,
   output logic [REG_WIDTH-1:0] req_reg,
   output logic [BIT_WIDTH-1:0] req_data
);

   logic                 full_q;
   logic [REG_WIDTH-1:0] reg_q;
   logic [BIT_WIDTH-1:0] data_q;

   // Handshake: free slot, or the held entry leaves this cycle; reg-0 transfers never fill
   always_comb begin
      ready = !full_q || drain;
      fill  = valid && ready && (in_reg != REG_WIDTH'(REG_ZERO));
   end

   // Slot storage: a fill takes precedence over a drain on the same edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q <= 1'b0;
         reg_q  <= '0;
         data_q <= '0;
      end else if (fill) begin
         full_q <= 1'b1;
         reg_q  <= in_reg;
         data_q <= in_data;
      end else if (drain) begin
         full_q <= 1'b0;
      end
   end

   assign full     = full_q;
   assign req_reg  = reg_q;
   assign req_data = data_q;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Shares the register file write port between ALU and memory
//                load writebacks. Each requester owns a one-entry slot; one
//                slot is drained per cycle onto registered write lines.
//                Same-register collisions are resolved oldest-first so the
//                port sees those writes in acceptance order.
//  Config      : WB_RR_EN defined   -> round-robin between different-register
//                                      requests when both slots are full
//                WB_RR_EN undefined -> fixed MEM>ALU priority with an ALU
//                                      starvation limit of STARVE_MAX grants
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int BIT_WIDTH  = 32,
   parameter int REG_WIDTH  = $clog2(BIT_WIDTH),
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alu_valid,
   output logic                 alu_ready,
   input  logic [REG_WIDTH-1:0] alu_reg,
   input  logic [BIT_WIDTH-1:0] alu_data,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [REG_WIDTH-1:0] mem_reg,
   input  logic [BIT_WIDTH-1:0] mem_data,
   output logic                 write,
   output logic [REG_WIDTH-1:0] Write_reg,
   output logic [BIT_WIDTH-1:0] Write_Data,
   output logic                 busy
);

   logic                 alu_full, alu_fill, alu_drain;
   logic [REG_WIDTH-1:0] alu_req_reg;
   logic [BIT_WIDTH-1:0] alu_req_data;
   logic                 mem_full, mem_fill, mem_drain;
   logic [REG_WIDTH-1:0] mem_req_reg;
   logic [BIT_WIDTH-1:0] mem_req_data;

   logic                 both_full;
   logic                 same_reg;
   logic                 grant_any;
   wb_src_e              grant_src;
   wb_src_e              policy_src;
   logic                 mem_older;

   wb_slot #(
      .BIT_WIDTH (BIT_WIDTH),
      .REG_WIDTH (REG_WIDTH)
   ) u_alu_slot (
      .clk      (clk),
      .rst      (rst),
      .valid    (alu_valid),
      .ready    (alu_ready),
      .in_reg   (alu_reg),
      .in_data  (alu_data),
      .drain    (alu_drain),
      .full     (alu_full),
      .fill     (alu_fill),
      .req_reg  (alu_req_reg),
      .req_data (alu_req_data)
   );

   wb_slot #(
      .BIT_WIDTH (BIT_WIDTH),
      .REG_WIDTH (REG_WIDTH)
   ) u_mem_slot (
      .clk      (clk),
      .rst      (rst),
      .valid    (mem_valid),
      .ready    (mem_ready),
      .in_reg   (mem_reg),
      .in_data  (mem_data),
      .drain    (mem_drain),
      .full     (mem_full),
      .fill     (mem_fill),
      .req_reg  (mem_req_reg),
      .req_data (mem_req_data)
   );

   // Grant selection: lone slot wins; same-register pair goes oldest-first; otherwise the policy decides
   always_comb begin
      both_full = alu_full && mem_full;
      same_reg  = (alu_req_reg == mem_req_reg);
      grant_any = alu_full || mem_full;
      grant_src = WB_ALU;
      if (both_full) begin
         if (same_reg) begin
            grant_src = mem_older ? WB_MEM : WB_ALU;
         end else begin
            grant_src = policy_src;
         end
      end else if (mem_full) begin
         grant_src = WB_MEM;
      end
      alu_drain = alu_full && (grant_src == WB_ALU);
      mem_drain = mem_full && (grant_src == WB_MEM);
   end

   // Age tracking: a slot filling while the other stays occupied becomes the younger one;
   // simultaneous fills make the ALU entry the older one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_older <= 1'b0;
      end else if (alu_fill && mem_fill) begin
         mem_older <= 1'b0;
      end else if (alu_fill && mem_full && !mem_drain) begin
         mem_older <= 1'b1;
      end else if (mem_fill && alu_full && !alu_drain) begin
         mem_older <= 1'b0;
      end
   end

`ifdef WB_RR_EN
   wb_src_e rr_ptr;

   // Round-robin choice for different-register contention
   always_comb begin
      policy_src = rr_ptr;
   end

   // Pointer moves to the loser after every grant made with both slots occupied
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr <= WB_ALU;
      end else if (both_full) begin
         rr_ptr <= wb_other(grant_src);
      end
   end
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt;

   // Fixed MEM priority until the ALU has waited STARVE_MAX memory grants
   always_comb begin
      policy_src = (starve_cnt == STARVE_LIM) ? WB_ALU : WB_MEM;
   end

   // Count memory grants taken while the ALU is waiting; an ALU grant clears the count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (alu_drain) begin
         starve_cnt <= '0;
      end else if (mem_drain && alu_full && (starve_cnt != STARVE_LIM)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end
`endif

   // Registered write port: pulse on each grant, hold index/data otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write      <= 1'b0;
         Write_reg  <= '0;
         Write_Data <= '0;
      end else begin
         write <= grant_any;
         if (grant_any) begin
            Write_reg  <= (grant_src == WB_MEM) ? mem_req_reg  : alu_req_reg;
            Write_Data <= (grant_src == WB_MEM) ? mem_req_data : alu_req_data;
         end
      end
   end

   // Activity indicator for pipeline stall/flush logic
   always_comb begin
      busy = alu_full || mem_full || write;
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter. A request-level
//                model (pending entries with acceptance sequence numbers)
//                predicts ready, write pulses, write index/data and busy.
//                Directed scenarios cover reset, latency, register 0,
//                same-register ordering and the contention policy (WB_RR_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   localparam int BW   = 32;
   localparam int RW   = 5;
   localparam int SMAX = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          alu_valid = 1'b0;
   logic          alu_ready;
   logic [RW-1:0] alu_reg = '0;
   logic [BW-1:0] alu_data = '0;
   logic          mem_valid = 1'b0;
   logic          mem_ready;
   logic [RW-1:0] mem_reg = '0;
   logic [BW-1:0] mem_data = '0;
   logic          write;
   logic [RW-1:0] Write_reg;
   logic [BW-1:0] Write_Data;
   logic          busy;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .BIT_WIDTH  (BW),
      .REG_WIDTH  (RW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_reg    (alu_reg),
      .alu_data   (alu_data),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_reg    (mem_reg),
      .mem_data   (mem_data),
      .write      (write),
      .Write_reg  (Write_reg),
      .Write_Data (Write_Data),
      .busy       (busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: outstanding request per requester with its acceptance order
   typedef struct {
      bit      pend;
      wb_req_t e;
      int      seq;
   } ent_t;

   ent_t          ma, mm;
   int            seq_ctr;
`ifdef WB_RR_EN
   bit            rr_mem;
`else
   int            starve;
`endif
   bit            ew;
   logic [RW-1:0] ewr;
   logic [BW-1:0] ewd;
   bit            a_acc, m_acc;

   task automatic model_reset();
      ma.pend = 0; ma.e = '0; ma.seq = 0;
      mm.pend = 0; mm.e = '0; mm.seq = 0;
      seq_ctr = 0;
`ifdef WB_RR_EN
      rr_mem = 0;
`else
      starve = 0;
`endif
      ew = 0; ewr = '0; ewd = '0;
      a_acc = 0; m_acc = 0;
   endtask

   // One clock: drive at the falling edge, predict, check ready, then check outputs at the next falling edge
   task automatic step(input bit av, input logic [RW-1:0] ar, input logic [BW-1:0] ad,
                       input bit mv, input logic [RW-1:0] mr, input logic [BW-1:0] md);
      int g;
      bit both;
      alu_valid = av; alu_reg = ar; alu_data = ad;
      mem_valid = mv; mem_reg = mr; mem_data = md;
      g    = 0;
      both = ma.pend && mm.pend;
      if (both) begin
         if (ma.e.rd == mm.e.rd) g = (ma.seq < mm.seq) ? 1 : 2;
`ifdef WB_RR_EN
         else g = rr_mem ? 2 : 1;
`else
         else g = (starve >= SMAX) ? 1 : 2;
`endif
      end else if (ma.pend) begin
         g = 1;
      end else if (mm.pend) begin
         g = 2;
      end
      #1;
      chk("alu_ready", alu_ready, (!ma.pend || g == 1));
      chk("mem_ready", mem_ready, (!mm.pend || g == 2));
      a_acc = av && (!ma.pend || g == 1);
      m_acc = mv && (!mm.pend || g == 2);
`ifdef WB_RR_EN
      if (both) rr_mem = (g == 1);
`else
      if (g == 1) starve = 0;
      else if (g == 2 && ma.pend && starve < SMAX) starve++;
`endif
      ew = (g != 0);
      if (g == 1) begin
         ewr = ma.e.rd; ewd = ma.e.data; ma.pend = 0;
      end else if (g == 2) begin
         ewr = mm.e.rd; ewd = mm.e.data; mm.pend = 0;
      end
      if (a_acc && ar != 0) begin
         ma.pend = 1; ma.e.rd = ar; ma.e.data = ad; ma.seq = seq_ctr;
      end
      if (m_acc && mr != 0) begin
         mm.pend = 1; mm.e.rd = mr; mm.e.data = md; mm.seq = seq_ctr + 1;
      end
      seq_ctr += 2;
      @(posedge clk);
      @(negedge clk);
      chk("write", write, ew);
      chk("Write_reg", Write_reg, ewr);
      chk("Write_Data", Write_Data, ewd);
      chk("busy", busy, (ma.pend || mm.pend || ew));
   endtask

   task automatic idle();
      step(0, '0, '0, 0, '0, '0);
   endtask

   int            areg, mreg, mem_w, alu_at;
   bit            a_v, src, prev_src;
   bit            rav, rmv;
   logic [RW-1:0] rar, rmr;
   logic [BW-1:0] rad, rmd;

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_write", write, 0);
      chk("rst_Write_reg", Write_reg, 0);
      chk("rst_Write_Data", Write_Data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_ready", alu_ready, 1);
      chk("rst_mem_ready", mem_ready, 1);
      rst = 1'b1;
      @(negedge clk);

      // Single ALU writeback: accepted at edge N, write visible after edge N+1 for one cycle
      step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
      chk("t2_no_early_write", write, 0);
      idle();
      chk("t2_write", write, 1);
      chk("t2_reg", Write_reg, 5);
      chk("t2_data", Write_Data, 32'hDEADBEEF);
      idle();
      chk("t2_single_pulse", write, 0);
      chk("t2_hold_data", Write_Data, 32'hDEADBEEF);

      // Register 0 load is swallowed
      step(0, '0, '0, 1, 5'd0, 32'h1234);
      chk("t3_mem_ready", mem_ready, 1);
      chk("t3_busy", busy, 0);
      idle();
      chk("t3_no_write", write, 0);
      chk("t3_busy2", busy, 0);

      // Same-register collision: ALU value first, MEM value second
      step(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
      idle();
      chk("t4_first_write", write, 1);
      chk("t4_first_reg", Write_reg, 7);
      chk("t4_first_data", Write_Data, 32'h1);
      idle();
      chk("t4_second_write", write, 1);
      chk("t4_second_data", Write_Data, 32'h2);
      idle();
      chk("t4_done", write, 0);

      // Asynchronous reset with both slots occupied discards them
      step(1, 5'd9, 32'hA9, 1, 5'd10, 32'hB10);
      step(1, 5'd11, 32'hA11, 1, 5'd12, 32'hB12);
      rst = 1'b0;
      #1;
      chk("t1_write", write, 0);
      chk("t1_alu_ready", alu_ready, 1);
      chk("t1_mem_ready", mem_ready, 1);
      chk("t1_busy", busy, 0);
      model_reset();
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle();
         chk("t1_no_late_write", write, 0);
      end

`ifndef WB_RR_EN
      // Starvation bound: ALU reg 3 waits for exactly SMAX memory writes
      mreg = 8; a_v = 1; mem_w = 0; alu_at = -1;
      for (int c = 0; c < 20 && alu_at < 0; c++) begin
         step(a_v, 5'd3, 32'h333, 1, mreg[RW-1:0], mreg);
         if (a_acc) a_v = 0;
         if (m_acc) mreg = (mreg == 15) ? 8 : mreg + 1;
         if (write) begin
            if (Write_reg == 5'd3) alu_at = mem_w;
            else mem_w++;
         end
      end
      chk("t5_mem_writes_before_alu", alu_at, SMAX);
`else
      // Round-robin: continuous streams to distinct registers alternate every cycle
      areg = 1; mreg = 16; prev_src = 0;
      for (int c = 0; c < 16; c++) begin
         step(1, areg[RW-1:0], areg, 1, mreg[RW-1:0], mreg);
         if (a_acc) areg = (areg == 15) ? 1 : areg + 1;
         if (m_acc) mreg = (mreg == 31) ? 16 : mreg + 1;
         if (c >= 1) begin
            chk("t6_write_every_cycle", write, 1);
            src = (Write_reg >= 16);
            if (c >= 2) chk("t6_alternate", src, !prev_src);
            prev_src = src;
         end
      end
`endif
      for (int i = 0; i < 4; i++) idle();

      // Randomized traffic against the model; small register range forces collisions and reg 0
      rav = 0; rmv = 0; rar = '0; rmr = '0; rad = '0; rmd = '0;
      for (int c = 0; c < 400; c++) begin
         if (!(rav && !a_acc)) begin
            rav = ($urandom_range(0, 3) != 0);
            rar = ($urandom_range(0, 3) == 0) ? RW'($urandom) : RW'($urandom_range(0, 3));
            rad = $urandom;
         end
         if (!(rmv && !m_acc)) begin
            rmv = ($urandom_range(0, 3) != 0);
            rmr = ($urandom_range(0, 3) == 0) ? RW'($urandom) : RW'($urandom_range(0, 3));
            rmd = $urandom;
         end
         step(rav, rar, rad, rmv, rmr, rmd);
      end
      for (int i = 0; i < 4; i++) idle();
      chk("final_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
